// File: rtl/operand_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// operand_fwd_ctrl : EX-stage operand forwarding selects and load-use stall
//                    generation from a two-slot (EX, MEM) destination scoreboard.
// Revision 1.0
// ============================================================================
module operand_fwd_ctrl #(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0]        SEL_RF    = 2'b00;
  localparam logic [1:0]        SEL_MEMWB = 2'b01;
  localparam logic [1:0]        SEL_EXMEM = 2'b10;
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};

  // Scoreboard slots: instruction currently in EX and the one in MEM
  logic              ex_vld;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_ld;
  logic              mem_vld;
  logic [REG_AW-1:0] mem_dst;

  logic              zero_a, zero_b;
  logic              hit_ex_a, hit_ex_b;
  logic              hit_mem_a, hit_mem_b;
  logic              dec_vld;
  logic              kill;
  logic [1:0]        nxt_sel_a, nxt_sel_b;

  always_comb begin
    zero_a    = (ZERO_REG != 0) && (id_src_a == REG_ZERO);
    zero_b    = (ZERO_REG != 0) && (id_src_b == REG_ZERO);
    hit_ex_a  = ex_vld  && (ex_dst  == id_src_a) && !zero_a;
    hit_ex_b  = ex_vld  && (ex_dst  == id_src_b) && !zero_b;
    hit_mem_a = mem_vld && (mem_dst == id_src_a) && !zero_a;
    hit_mem_b = mem_vld && (mem_dst == id_src_b) && !zero_b;

    stall   = id_valid && ex_ld && (hit_ex_a || hit_ex_b);
    dec_vld = id_valid && id_wr_en && !((ZERO_REG != 0) && (id_dst == REG_ZERO));
    kill    = stall || flush || !id_valid;

    // The younger producer (EX) holds the newest value, so it wins over MEM
    nxt_sel_a = hit_ex_a ? SEL_EXMEM : (hit_mem_a ? SEL_MEMWB : SEL_RF);
    nxt_sel_b = hit_ex_b ? SEL_EXMEM : (hit_mem_b ? SEL_MEMWB : SEL_RF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_vld    <= 1'b0;
      ex_dst    <= REG_ZERO;
      ex_ld     <= 1'b0;
      mem_vld   <= 1'b0;
      mem_dst   <= REG_ZERO;
      sel_a     <= SEL_RF;
      sel_b     <= SEL_RF;
      stall_cnt <= {CNT_W{1'b0}};
    end else begin
      mem_vld <= ex_vld;
      mem_dst <= ex_dst;
      if (kill) begin
        ex_vld <= 1'b0;
        ex_ld  <= 1'b0;
        sel_a  <= SEL_RF;
        sel_b  <= SEL_RF;
      end else begin
        ex_vld <= dec_vld;
        ex_dst <= id_dst;
        ex_ld  <= id_is_load && dec_vld;
        sel_a  <= nxt_sel_a;
        sel_b  <= nxt_sel_b;
      end
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire
